// File: rtl/tile_link_pkg.sv
// rtl/tile_link_pkg.sv - shared word and link channel state types
package tile_link_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    LINK_IDLE,
    LINK_FULL,
    LINK_DONE
  } link_state_t;

endpackage

// File: rtl/link_channel.sv
// rtl/link_channel.sv - one direction of a tile link: single-word blocking write-until-read
module link_channel
  import tile_link_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  word_t            send_data,
  input  logic             send_ready,
  input  logic             recv_ready,
  output logic             send_done,
  output logic             recv_valid,
  output word_t            recv_data,
  output logic [CNT_W-1:0] count
);

  link_state_t state;

  // recv_data doubles as the word buffer: it only needs to hold the word while FULL.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= LINK_IDLE;
      send_done  <= 1'b0;
      recv_valid <= 1'b0;
      recv_data  <= '0;
      count      <= '0;
    end else begin
      case (state)
        LINK_IDLE: begin
          if (send_ready) begin
            state      <= LINK_FULL;
            recv_valid <= 1'b1;
            recv_data  <= send_data;
          end
        end
        LINK_FULL: begin
          if (recv_ready) begin
            state      <= LINK_DONE;
            recv_valid <= 1'b0;
            recv_data  <= '0;
            send_done  <= 1'b1;
            count      <= count + 1'b1;
          end
        end
        LINK_DONE: begin
          // Any send_ready here is the sender's stale request for the word just acked.
          state     <= LINK_IDLE;
          send_done <= 1'b0;
        end
        default: begin
          state      <= LINK_IDLE;
          send_done  <= 1'b0;
          recv_valid <= 1'b0;
          recv_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tile_link.sv
// rtl/tile_link.sv - point-to-point link between neighbouring tiles A and B
module tile_link
  import tile_link_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  word_t            a_send_data,
  input  logic             a_send_ready,
  input  logic             a_recv_ready,
  output logic             a_send_done,
  output logic             a_recv_valid,
  output word_t            a_recv_data,
  input  word_t            b_send_data,
  input  logic             b_send_ready,
  input  logic             b_recv_ready,
  output logic             b_send_done,
  output logic             b_recv_valid,
  output word_t            b_recv_data,
  output logic [CNT_W-1:0] ab_count,
  output logic [CNT_W-1:0] ba_count
);

  link_channel #(.CNT_W(CNT_W)) u_ab (
    .clk        (clk),
    .nrst       (nrst),
    .send_data  (a_send_data),
    .send_ready (a_send_ready),
    .recv_ready (b_recv_ready),
    .send_done  (a_send_done),
    .recv_valid (b_recv_valid),
    .recv_data  (b_recv_data),
    .count      (ab_count)
  );

  link_channel #(.CNT_W(CNT_W)) u_ba (
    .clk        (clk),
    .nrst       (nrst),
    .send_data  (b_send_data),
    .send_ready (b_send_ready),
    .recv_ready (a_recv_ready),
    .send_done  (b_send_done),
    .recv_valid (a_recv_valid),
    .recv_data  (a_recv_data),
    .count      (ba_count)
  );

endmodule

// File: tb/tb_tile_link.sv
// tb/tb_tile_link.sv - self-checking bench for tile_link with a transaction-level model
module tb_tile_link;
  import tile_link_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  word_t       a_send_data = '0, b_send_data = '0;
  logic        a_send_ready = 1'b0, a_recv_ready = 1'b0;
  logic        b_send_ready = 1'b0, b_recv_ready = 1'b0;

  logic        a_send_done, a_recv_valid, b_send_done, b_recv_valid;
  word_t       a_recv_data, b_recv_data;
  logic [15:0] ab_count, ba_count;

  logic        w_a_send_done, w_a_recv_valid, w_b_send_done, w_b_recv_valid;
  word_t       w_a_recv_data, w_b_recv_data;
  logic [1:0]  w_ab_count, w_ba_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tile_link dut (
    .clk(clk), .nrst(nrst),
    .a_send_data(a_send_data), .a_send_ready(a_send_ready), .a_recv_ready(a_recv_ready),
    .a_send_done(a_send_done), .a_recv_valid(a_recv_valid), .a_recv_data(a_recv_data),
    .b_send_data(b_send_data), .b_send_ready(b_send_ready), .b_recv_ready(b_recv_ready),
    .b_send_done(b_send_done), .b_recv_valid(b_recv_valid), .b_recv_data(b_recv_data),
    .ab_count(ab_count), .ba_count(ba_count)
  );

  tile_link #(.CNT_W(2)) dut_w (
    .clk(clk), .nrst(nrst),
    .a_send_data(a_send_data), .a_send_ready(a_send_ready), .a_recv_ready(a_recv_ready),
    .a_send_done(w_a_send_done), .a_recv_valid(w_a_recv_valid), .a_recv_data(w_a_recv_data),
    .b_send_data(b_send_data), .b_send_ready(b_send_ready), .b_recv_ready(b_recv_ready),
    .b_send_done(w_b_send_done), .b_recv_valid(w_b_recv_valid), .b_recv_data(w_b_recv_data),
    .ab_count(w_ab_count), .ba_count(w_ba_count)
  );

  // Model per direction (0: A->B, 1: B->A): a one-word mailbox plus a pending ack.
  logic        m_has [2] = '{1'b0, 1'b0};
  word_t       m_word[2] = '{16'h0, 16'h0};
  logic        m_ack [2] = '{1'b0, 1'b0};
  int unsigned m_cnt [2] = '{0, 0};

  task automatic model_step(input int d, input logic snd, input word_t dat, input logic rcv);
    if (m_ack[d]) begin
      m_ack[d] = 1'b0;
    end else if (m_has[d]) begin
      if (rcv) begin
        m_has[d] = 1'b0;
        m_ack[d] = 1'b1;
        m_cnt[d] = m_cnt[d] + 1;
      end
    end else if (snd) begin
      m_has[d]  = 1'b1;
      m_word[d] = dat;
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int d = 0; d < 2; d++) begin
        m_has[d] = 1'b0; m_word[d] = '0; m_ack[d] = 1'b0; m_cnt[d] = 0;
      end
    end else begin
      model_step(0, a_send_ready, a_send_data, b_recv_ready);
      model_step(1, b_send_ready, b_send_data, a_recv_ready);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("m_b_recv_valid", 32'(b_recv_valid), 32'(m_has[0]));
    chk("m_b_recv_data", 32'(b_recv_data), m_has[0] ? 32'(m_word[0]) : 32'h0);
    chk("m_a_send_done", 32'(a_send_done), 32'(m_ack[0]));
    chk("m_a_recv_valid", 32'(a_recv_valid), 32'(m_has[1]));
    chk("m_a_recv_data", 32'(a_recv_data), m_has[1] ? 32'(m_word[1]) : 32'h0);
    chk("m_b_send_done", 32'(b_send_done), 32'(m_ack[1]));
    chk("m_ab_count", 32'(ab_count), m_cnt[0] % 65536);
    chk("m_ba_count", 32'(ba_count), m_cnt[1] % 65536);
    chk("m_w_ab_count", 32'(w_ab_count), m_cnt[0] % 4);
    chk("m_w_ba_count", 32'(w_ba_count), m_cnt[1] % 4);
    chk("m_w_b_recv_data", 32'(w_b_recv_data), 32'(b_recv_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_send_ready = 1'b0; a_recv_ready = 1'b0;
    b_send_ready = 1'b0; b_recv_ready = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle_inputs();
    tick();
    nrst = 1'b1;
  endtask

  int seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset held with random inputs: everything reads 0.
    for (int i = 0; i < 5; i++) begin
      a_send_data = word_t'($urandom); b_send_data = word_t'($urandom);
      a_send_ready = 1'($urandom); a_recv_ready = 1'($urandom);
      b_send_ready = 1'($urandom); b_recv_ready = 1'($urandom);
      tick();
      chk("rst_outputs", {26'h0, a_send_done, a_recv_valid, b_send_done, b_recv_valid,
                          |a_recv_data, |b_recv_data}, 32'h0);
      chk("rst_counts", {ab_count, ba_count}, 32'h0);
    end
    idle_inputs();
    nrst = 1'b1;
    tick();

    // Single transfer with B already waiting.
    a_send_data = 16'h07B; a_send_ready = 1'b1; b_recv_ready = 1'b1;
    tick();
    chk("single_valid", 32'(b_recv_valid), 32'h1);
    chk("single_data", 32'(b_recv_data), 32'h07B);
    chk("single_done_early", 32'(a_send_done), 32'h0);
    a_send_ready = 1'b0;
    tick();
    chk("single_done", 32'(a_send_done), 32'h1);
    chk("single_valid_drop", 32'(b_recv_valid), 32'h0);
    b_recv_ready = 1'b0;
    tick();
    chk("single_done_once", 32'(a_send_done), 32'h0);
    chk("single_count", 32'(ab_count), 32'h1);

    // Blocked writer.
    a_send_data = 16'h3FF; a_send_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("blocked_valid", 32'(b_recv_valid), 32'h1);
      chk("blocked_no_done", 32'(a_send_done), 32'h0);
      tick();
    end
    chk("blocked_data", 32'(b_recv_data), 32'h3FF);
    b_recv_ready = 1'b1;
    tick();
    chk("blocked_done", 32'(a_send_done), 32'h1);
    a_send_ready = 1'b0; b_recv_ready = 1'b0;
    tick();
    chk("blocked_count", 32'(ab_count), 32'h2);

    // Committed write survives send_ready drop and data change.
    a_send_data = 16'h123; a_send_ready = 1'b1;
    tick();
    a_send_ready = 1'b0; a_send_data = 16'h456;
    tick(); tick();
    chk("commit_data", 32'(b_recv_data), 32'h123);
    b_recv_ready = 1'b1;
    tick();
    chk("commit_done", 32'(a_send_done), 32'h1);
    b_recv_ready = 1'b0;
    tick();

    // Bidirectional.
    a_send_data = 16'h001; b_send_data = 16'h002; a_send_ready = 1'b1; b_send_ready = 1'b1;
    tick();
    a_send_ready = 1'b0; b_send_ready = 1'b0;
    tick();
    a_recv_ready = 1'b1; b_recv_ready = 1'b1;
    chk("bidir_a_data", 32'(a_recv_data), 32'h002);
    chk("bidir_b_data", 32'(b_recv_data), 32'h001);
    tick();
    chk("bidir_dones", {30'h0, a_send_done, b_send_done}, 32'h3);
    idle_inputs();
    tick();
    chk("bidir_counts", {ab_count, ba_count}, {16'd4, 16'd1});

    // Reset while FULL discards the word and never acks it.
    a_send_data = 16'h0AA; a_send_ready = 1'b1;
    tick();
    a_send_ready = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midrst_valid", 32'(b_recv_valid), 32'h0);
    tick();
    nrst = 1'b1; b_recv_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_done", 32'(a_send_done), 32'h0);
    end
    chk("midrst_count", 32'(ab_count), 32'h0);
    b_recv_ready = 1'b0;

    // Counter wrap on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_send_data = word_t'($urandom); a_send_ready = 1'b1; b_recv_ready = 1'b1;
      tick();
      a_send_ready = 1'b0;
      tick();
      chk("wrap_ab", 32'(w_ab_count), 32'(seq[i]));
      chk("wrap_ba", 32'(w_ba_count), 32'h0);
      tick();
    end
    idle_inputs();

    // Randomized traffic with occasional resets; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      a_send_data = word_t'($urandom); b_send_data = word_t'($urandom);
      a_send_ready = ($urandom_range(0, 2) != 0); b_send_ready = ($urandom_range(0, 2) != 0);
      a_recv_ready = ($urandom_range(0, 3) == 0); b_recv_ready = ($urandom_range(0, 1) == 0);
      nrst = ($urandom_range(0, 199) != 0);
      tick();
    end
    nrst = 1'b1;
    idle_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
